// File: rtl/relu_flatten.sv
// relu_flatten: buffers seq_len input vectors, applies ReLU on write,
// and streams the words back out one per transfer in channel-major order.
module relu_flatten #(
    parameter int DW      = 32,
    parameter int in_ch   = 4,
    parameter int seq_len = 8
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  i_EN,
    output logic                  o_busy,
    input  logic [DW*in_ch-1:0]   i_data,
    input  logic                  i_stb_in,
    output logic                  o_ack_in,
    output logic [DW-1:0]         o_data,
    output logic                  o_stb_out,
    input  logic                  i_ack_out,
    output logic                  o_last
);
    localparam int N  = seq_len * in_ch;
    localparam int CW = $clog2(N + 1);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wr_cnt, rd_idx;
    logic [DW-1:0] mem [N];
    logic          fire_in, fire_out;

    assign fire_in  = i_stb_in & o_ack_in;
    assign fire_out = o_stb_out & i_ack_out;

    always_ff @(posedge clk or posedge RSTn) begin
        if (RSTn) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_EN ? FILL : IDLE;
            FILL:    state_nx = (fire_in && wr_cnt == CW'(seq_len - 1)) ? DRAIN : FILL;
            DRAIN:   state_nx = (fire_out && o_last) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy    = state != IDLE;
        o_ack_in  = state == FILL;
        o_stb_out = state == DRAIN;
        o_last    = o_stb_out && rd_idx == CW'(N - 1);
        o_data    = o_stb_out ? mem[AW'(rd_idx)] : '0;
    end

    // Counters are held at zero for as long as the block sits in IDLE.
    always_ff @(posedge clk or posedge RSTn) begin
        if (RSTn) begin
            wr_cnt <= '0;
            rd_idx <= '0;
        end else if (state == IDLE) begin
            wr_cnt <= '0;
            rd_idx <= '0;
        end else begin
            if (fire_in)  wr_cnt <= wr_cnt + 1'b1;
            if (fire_out) rd_idx <= rd_idx + 1'b1;
        end
    end

    // Lane c of vector t lands at c*seq_len+t; negative words store as zero.
    always_ff @(posedge clk) begin
        if (fire_in)
            for (int c = 0; c < in_ch; c++)
                mem[AW'(c * seq_len) + AW'(wr_cnt)] <=
                    i_data[c*DW + DW-1] ? '0 : i_data[c*DW +: DW];
    end
endmodule

// File: tb/tb_relu_flatten.sv
// tb_relu_flatten: directed frames checked against a queue-based flatten/ReLU model.
module tb_relu_flatten;
    localparam int DW = 32;
    localparam int CH = 4;
    localparam int SL = 8;
    localparam int N  = SL * CH;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             stb_in = 1'b0;
    logic             ack_out = 1'b1;
    logic             bp = 1'b0;
    logic [DW*CH-1:0] data_in = '0;
    logic             busy, ack_in, stb_out, last;
    logic [DW-1:0]    data_out;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pos = 0;
    logic [31:0] vecs [SL][CH];
    logic [31:0] obs [N];
    exp_t        q[$];

    relu_flatten #(.DW(DW), .in_ch(CH), .seq_len(SL)) dut (
        .clk(clk), .RSTn(rst), .i_EN(en), .o_busy(busy),
        .i_data(data_in), .i_stb_in(stb_in), .o_ack_in(ack_in),
        .o_data(data_out), .o_stb_out(stb_out), .i_ack_out(ack_out),
        .o_last(last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] relu(input logic [31:0] w);
        return ($signed(w) < 0) ? 32'd0 : w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic(input int off);
        for (int t = 0; t < SL; t++)
            for (int c = 0; c < CH; c++)
                vecs[t][c] = 32'(t + 16 * c + off);
    endtask

    task automatic push_exp;
        pos = 0;
        for (int c = 0; c < CH; c++)
            for (int t = 0; t < SL; t++)
                q.push_back('{relu(vecs[t][c]), (c == CH-1 && t == SL-1)});
    endtask

    task automatic start;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic fill(input bit gap, input bit abuse);
        logic sv;
        int   b;
        for (int t = 0; t < SL; t++) begin
            if (gap)
                repeat ($urandom_range(0, 2)) begin
                    stb_in = 1'b0;
                    tick();
                end
            sv = en;
            if (abuse && t == 3) en = 1'b1;
            stb_in = 1'b1;
            for (int c = 0; c < CH; c++) data_in[c*DW +: DW] = vecs[t][c];
            b = 0;
            while (!ack_in && b < 50) begin
                tick();
                b++;
            end
            if (b == 50) chk("fill ack timeout", 32'(ack_in), 32'd1);
            tick();
            stb_in = 1'b0;
            en = sv;
        end
        chk("first word latency", 32'(stb_out), 32'd1);
    endtask

    task automatic drain_wait(input bit abuse);
        int b = 0;
        if (abuse) begin
            repeat (3) tick();
            en = 1'b1;
            stb_in = 1'b1;
            data_in = {CH{32'h7EADBEEF}};
            tick();
            en = 1'b0;
            stb_in = 1'b0;
        end
        while (q.size() != 0 && b < 2000) begin
            tick();
            b++;
        end
        if (q.size() != 0) chk("drain timeout", 32'(q.size()), 32'd0);
        chk("busy after last", 32'(busy), 32'd0);
    endtask

    // Compare process: every output transfer against the model, plus hold stability.
    initial begin
        logic        hold;
        logic [31:0] hd;
        exp_t        e;
        hold = 1'b0;
        hd = '0;
        forever begin
            @(negedge clk);
            if (rst) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold stb_out", 32'(stb_out), 32'd1);
                    chk("hold data", data_out, hd);
                end
                if (stb_out && ack_out) begin
                    if (q.size() == 0) chk("unexpected word", 32'(stb_out), 32'd0);
                    else begin
                        e = q.pop_front();
                        chk("data", data_out, e.d);
                        chk("last", 32'(last), 32'(e.l));
                        if (pos < N) obs[pos] = data_out;
                        pos++;
                    end
                end else if (stb_out && q.size() == 0)
                    chk("stale stb_out", 32'(stb_out), 32'd0);
                hold = stb_out && !ack_out;
                hd = data_out;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ack_out = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int b;
        repeat (3) tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ack_in", 32'(ack_in), 32'd0);
        chk("reset stb_out", 32'(stb_out), 32'd0);
        chk("reset last", 32'(last), 32'd0);
        chk("reset data", data_out, 32'd0);
        rst = 1'b0;
        tick();

        set_basic(0);
        push_exp();
        start();
        fill(0, 0);
        drain_wait(0);
        chk("basic w0", obs[0], 32'd0);
        chk("basic w7", obs[7], 32'd7);
        chk("basic w8", obs[8], 32'd16);
        chk("basic w16", obs[16], 32'd32);
        chk("basic w31", obs[31], 32'd55);

        set_basic(0);
        vecs[0][0] = 32'hFFFFFFFF;
        vecs[0][1] = 32'h80000000;
        vecs[0][2] = 32'h7FFFFFFF;
        vecs[0][3] = 32'h00000000;
        push_exp();
        start();
        fill(0, 0);
        drain_wait(0);
        chk("relu lane0", obs[0], 32'd0);
        chk("relu lane1", obs[8], 32'd0);
        chk("relu lane2", obs[16], 32'h7FFFFFFF);
        chk("relu lane3", obs[24], 32'd0);

        bp = 1'b1;
        set_basic(0);
        push_exp();
        start();
        fill(1, 0);
        drain_wait(0);
        bp = 1'b0;
        chk("bp word count", 32'(pos), 32'd32);
        chk("bp w31", obs[31], 32'd55);

        stb_in = 1'b1;
        data_in = {CH{32'h12345678}};
        repeat (3) begin
            tick();
            chk("idle ack_in", 32'(ack_in), 32'd0);
        end
        stb_in = 1'b0;
        set_basic(0);
        push_exp();
        start();
        fill(0, 1);
        drain_wait(1);
        chk("abuse word count", 32'(pos), 32'd32);

        set_basic(0);
        push_exp();
        start();
        fill(0, 0);
        b = 0;
        while (pos < 10 && b < 100) begin
            tick();
            b++;
        end
        #2 rst = 1'b1;
        #1;
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset stb_out", 32'(stb_out), 32'd0);
        chk("mid reset last", 32'(last), 32'd0);
        chk("mid reset data", data_out, 32'd0);
        q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post reset busy", 32'(busy), 32'd0);
        set_basic(200);
        push_exp();
        start();
        fill(0, 0);
        drain_wait(0);
        chk("post reset count", 32'(pos), 32'd32);
        chk("post reset w0", obs[0], 32'd200);

        set_basic(0);
        push_exp();
        en = 1'b1;
        tick();
        fill(0, 0);
        drain_wait(0);
        set_basic(100);
        push_exp();
        tick();
        chk("b2b fill start", 32'(ack_in), 32'd1);
        en = 1'b0;
        fill(0, 0);
        drain_wait(0);
        chk("b2b w31", obs[31], 32'd155);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
